// File: rtl/lfm_pkg.sv
// lfm_pkg: shared widths, FSM state codes, quadrant codes and the sine table generator
// for the LFM chirp generator.
package lfm_pkg;
   localparam int DATA_W_DEF  = 16;
   localparam int PHASE_W_DEF = 32;
   localparam int LUT_AW_DEF  = 10;
   localparam int CNT_W_DEF   = 14;
   localparam int AMP_DEF     = 32767;
   localparam int LAT         = 4;
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_DELAY = 2'd1;
   localparam state_t S_CHIRP = 2'd2;
   localparam state_t S_DRAIN = 2'd3;
   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;
   // Elaboration-time round(amp*sin(pi/2 * i/2^aw)); the Taylor series converges far below one LSB
   function automatic int sin_q(int i, int aw, int amp);
      real x, t, s;
      x = 1.5707963267948966 * real'(i) / real'(2 ** aw);
      t = x;
      s = 0.0;
      for (int n = 1; n <= 25; n += 2) begin
         s = s + t;
         t = -t * x * x / real'((n + 1) * (n + 2));
      end
      return $rtoi(s * real'(amp) + 0.5);
   endfunction
endpackage

// File: rtl/lfm_sincos_lut.sv
// lfm_sincos_lut: 4-stage quarter-wave sin/cos lookup (fold, ROM read, ROM reg, sign),
// carrying valid and a tag; outputs are zero while not valid.
module lfm_sincos_lut import lfm_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LUT_AW = LUT_AW_DEF,
   parameter int AMP    = AMP_DEF,
   parameter int TAG_W  = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [LUT_AW+1:0]   phase,
   input  logic                valid_in,
   input  logic [TAG_W-1:0]    tag_in,
   output logic [DATA_W-1:0]   cos_out,
   output logic [DATA_W-1:0]   sin_out,
   output logic                valid_out,
   output logic [TAG_W-1:0]    tag_out
);
   localparam logic [LUT_AW:0] FULL = {1'b1, {LUT_AW{1'b0}}};
   logic [DATA_W-1:0] rom [0:2**LUT_AW];
   for (genvar i = 0; i <= 2**LUT_AW; i++) begin : g_rom
      localparam logic [DATA_W-1:0] V = DATA_W'(sin_q(i, LUT_AW, AMP));
      assign rom[i] = V;
   end
   logic [1:0] quad;
   logic [LUT_AW:0] r_up, r_dn, a_s, a_c;
   logic [DATA_W-1:0] s2, c2, s3, c3;
   logic [2:0] v, ns, nc;
   logic [2:0][TAG_W-1:0] t;
   assign quad = phase[LUT_AW+1:LUT_AW];
   assign r_up = {1'b0, phase[LUT_AW-1:0]};
   assign r_dn = FULL - r_up;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_s <= '0;
         a_c <= '0;
         {s2, c2, s3, c3} <= '0;
         {v, ns, nc} <= '0;
         t <= '0;
         {cos_out, sin_out, valid_out, tag_out} <= '0;
      end else begin
         a_s <= quad[0] ? r_dn : r_up;
         a_c <= quad[0] ? r_up : r_dn;
         v <= {v[1:0], valid_in};
         ns <= {ns[1:0], quad == Q2 || quad == Q3};
         nc <= {nc[1:0], quad == Q1 || quad == Q2};
         t <= {t[1:0], tag_in};
         s2 <= rom[a_s];
         c2 <= rom[a_c];
         s3 <= s2;
         c3 <= c2;
         valid_out <= v[2];
         sin_out <= v[2] ? (ns[2] ? -s3 : s3) : '0;
         cos_out <= v[2] ? (nc[2] ? -c3 : c3) : '0;
         tag_out <= v[2] ? t[2] : '0;
      end
endmodule

// File: rtl/lfm_pulse_gen.sv
// lfm_pulse_gen: per-PRI baseband LFM chirp generator (I/Q), with edge detect,
// delay/chirp/drain sequencing and quadratic phase accumulation.
module lfm_pulse_gen import lfm_pkg::*; #(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int LUT_AW  = LUT_AW_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int AMP     = AMP_DEF
) (
   input  logic               clk_200M,
   input  logic               rst,
   input  logic               enable,
   input  logic               PRI,
   input  logic [PHASE_W-1:0] start_freq,
   input  logic [PHASE_W-1:0] chirp_rate,
   input  logic [CNT_W-1:0]   pulse_len,
   input  logic [CNT_W-1:0]   tx_delay,
   output logic [DATA_W-1:0]  tx_I,
   output logic [DATA_W-1:0]  tx_Q,
   output logic               tx_valid,
   output logic               tx_busy,
   output logic [CNT_W-1:0]   sample_cnt,
   output logic               pri_miss
);
   state_t state;
   logic pri_d, pri_edge, accept, last;
   logic [PHASE_W-1:0] phase, freq, rate;
   logic [CNT_W-1:0] len, dly, cnt, lim;
   assign pri_edge = PRI & ~pri_d;
   assign accept = pri_edge & (state == S_IDLE) & enable & (pulse_len != '0);
   assign lim = state == S_DELAY ? dly : state == S_CHIRP ? len : CNT_W'(LAT);
   assign last = cnt == lim - 1'b1;
   // DRAIN covers the sincos pipeline, so IDLE also means the pipeline is empty
   assign tx_busy = state != S_IDLE;
   always_ff @(posedge clk_200M or posedge rst)
      if (rst) begin
         state <= S_IDLE;
         {pri_d, pri_miss} <= '0;
         {phase, freq, rate} <= '0;
         {len, dly, cnt} <= '0;
      end else begin
         pri_d <= PRI;
         pri_miss <= pri_edge & ~accept & (pulse_len != '0);
         if (accept) begin
            freq <= start_freq;
            rate <= chirp_rate;
            len <= pulse_len;
            dly <= tx_delay;
            phase <= '0;
            cnt <= '0;
            state <= tx_delay != '0 ? S_DELAY : S_CHIRP;
         end else if (state != S_IDLE) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last)
               state <= state == S_DELAY ? S_CHIRP : state == S_CHIRP ? S_DRAIN : S_IDLE;
            if (state == S_CHIRP) begin
               phase <= phase + freq;
               freq <= freq + rate;
            end
         end
      end
   lfm_sincos_lut #(.DATA_W(DATA_W), .LUT_AW(LUT_AW), .AMP(AMP), .TAG_W(CNT_W)) u_lut (
      .clk       (clk_200M),
      .rst       (rst),
      .phase     (phase[PHASE_W-1 -: LUT_AW+2]),
      .valid_in  (state == S_CHIRP),
      .tag_in    (cnt),
      .cos_out   (tx_I),
      .sin_out   (tx_Q),
      .valid_out (tx_valid),
      .tag_out   (sample_cnt)
   );
endmodule

// File: tb/tb_lfm_pulse_gen.sv
// tb_lfm_pulse_gen: directed + randomized pulses checked against a closed-form
// chirp model (quadratic phase, real-valued cos/sin rounded to the output grid).
module tb_lfm_pulse_gen;
   logic clk_200M = 0, rst = 1, enable = 0, PRI = 0;
   logic [31:0] start_freq = 0, chirp_rate = 0;
   logic [13:0] pulse_len = 0, tx_delay = 0;
   logic [15:0] tx_I, tx_Q;
   logic [13:0] sample_cnt;
   logic tx_valid, tx_busy, pri_miss;
   int vecs = 0, errs = 0;

   lfm_pulse_gen dut (
      .clk_200M   (clk_200M),
      .rst        (rst),
      .enable     (enable),
      .PRI        (PRI),
      .start_freq (start_freq),
      .chirp_rate (chirp_rate),
      .pulse_len  (pulse_len),
      .tx_delay   (tx_delay),
      .tx_I       (tx_I),
      .tx_Q       (tx_Q),
      .tx_valid   (tx_valid),
      .tx_busy    (tx_busy),
      .sample_cnt (sample_cnt),
      .pri_miss   (pri_miss)
   );

   always #5 clk_200M = ~clk_200M;

   function automatic int rnd(input real r);
      return r >= 0.0 ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
   endfunction

   // Sample k of a chirp: phase = k*f0 + c*k(k-1)/2 mod 2^32, top 12 bits select the angle
   function automatic void ref_iq(input longint unsigned k, sf, cr, output int i, output int q);
      longint unsigned ph;
      real a;
      ph = (k * sf + cr * ((k * (k - 1)) / 2)) & 64'hFFFF_FFFF;
      a = 2.0 * 3.14159265358979323846 * real'(ph >> 20) / 4096.0;
      i = rnd(32767.0 * $cos(a));
      q = rnd(32767.0 * $sin(a));
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, tx_valid, 0);
      chk({tag, "_I"}, $signed(tx_I), 0);
      chk({tag, "_Q"}, $signed(tx_Q), 0);
      chk({tag, "_cnt"}, sample_cnt, 0);
      chk({tag, "_busy"}, tx_busy, 0);
   endtask

   // One accepted pulse; rep>0 raises a second edge at E+rep, abort>=0 resets at that sample
   task automatic pulse(input logic [31:0] sf, cr, input int len, dly, rep, abort);
      int k, ei, eq;
      bit v;
      start_freq = sf;
      chirp_rate = cr;
      pulse_len = 14'(len);
      tx_delay = 14'(dly);
      enable = 1;
      PRI = 1;
      for (int n = 1; n <= dly + len + 6; n++) begin
         @(negedge clk_200M);
         k = n - dly - 5;
         v = k >= 0 && k < len;
         chk("valid", tx_valid, 32'(v));
         if (v) ref_iq(longint'(k), longint'(sf), longint'(cr), ei, eq);
         else {ei, eq} = '0;
         chk("tx_I", $signed(tx_I), ei);
         chk("tx_Q", $signed(tx_Q), eq);
         chk("sample_cnt", sample_cnt, v ? k : 0);
         chk("busy", tx_busy, 32'(n <= dly + 4 + len));
         chk("pri_miss", pri_miss, 32'(rep > 0 && n == rep + 1));
         PRI = rep > 0 && n == rep;
         if (n == 1) begin
            start_freq = $urandom;
            chirp_rate = $urandom;
            pulse_len = 14'($urandom | 1);
            tx_delay = 14'($urandom);
         end
         if (n == 2) enable = 0;
         if (abort >= 0 && k == abort) begin
            rst = 1;
            #1;
            chk_idle("abort");
            @(negedge clk_200M);
            rst = 0;
            return;
         end
      end
   endtask

   task automatic rej(input bit en, input int len);
      enable = en;
      pulse_len = 14'(len);
      tx_delay = 0;
      PRI = 1;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk_200M);
         chk("rej_miss", pri_miss, 32'(n == 1 && len != 0));
         chk_idle("rej");
         PRI = 0;
      end
      enable = 1;
   endtask

   initial begin
      repeat (3) @(negedge clk_200M);
      chk_idle("reset");
      chk("reset_miss", pri_miss, 0);
      rst = 0;
      @(negedge clk_200M);
      pulse(32'h0, 32'h0, 4, 0, 0, -1);
      pulse(32'h4000_0000, 32'h0, 4, 0, 0, -1);
      pulse(32'h0, 32'h4000_0000, 3, 0, 0, -1);
      pulse($urandom, $urandom, 4000, 10, 100, -1);
      rej(0, 4);
      rej(1, 0);
      pulse($urandom, $urandom, 200, 3, 0, 50);
      pulse($urandom, $urandom, 100, 0, 0, -1);
      repeat (6) pulse($urandom, $urandom, $urandom_range(1, 60), $urandom_range(0, 20), 0, -1);
      pulse($urandom, $urandom, 16383, 0, 0, -1);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
